// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory port.
// Port 0 is the CPU and port 1 is the DMA engine. Each transaction walks through
// IDLE -> ISSUE -> WAIT -> ACK and returns to IDLE. All outputs are registered.
// Build option: define MEM_ARB_TIMEOUT_EN to bound the WAIT state to TIMEOUT_CYC
// cycles. A transaction that times out completes with err=1. Without the macro,
// WAIT waits for the memory indefinitely and err is tied low.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [14:0] addr0,
    input  logic [14:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w,
    output logic        mem_start,
    input  logic [31:0] mem_rdata,
    input  logic        mem_readrdy,
    input  logic        mem_saverdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t      state;
    logic        last_grant;   // 0: port 0 was served last, 1: port 1
    logic        lat_we;       // direction of the transaction in flight
    logic        winner;       // port chosen in IDLE this cycle
    logic        done;         // matching completion strobe seen in WAIT
    logic        timed_out;    // WAIT budget used up this cycle
    logic [1:0]  req_vec;
    logic [1:0]  we_vec;
    logic [1:0]  ack_vec;
    logic [14:0] addr_vec  [2];
    logic [31:0] wdata_vec [2];

    // Gather the two request ports into indexable form so the winner selects them.
    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;
    assign ack0         = ack_vec[0];
    assign ack1         = ack_vec[1];

    // A zero WAIT budget has no meaning, so it is rejected when the design is built.
    generate
        if (TIMEOUT_CYC == 0) begin : g_bad_timeout
            $error("mem_arbiter: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    // Round-robin choice. A lone requester wins. On a tie, the port not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req_vec[0] && req_vec[1]) begin
            winner = ~last_grant;
        end else if (req_vec[1]) begin
            winner = 1'b1;
        end
    end

    // Only the completion strobe that matches the latched direction counts.
    // The opposite strobe is ignored.
    always_comb begin
        done = lat_we ? mem_saverdy : mem_readrdy;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count WAIT cycles. The counter restarts from zero on every entry into WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Timeout happens in the last permitted WAIT cycle, so WAIT lasts exactly TIMEOUT_CYC cycles.
    assign timed_out = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // err rises together with ack when the budget ran out first.
    // It is low on every normal completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == WAIT) begin
            err <= timed_out && !done;
        end else if (state == ACK) begin
            err <= 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    // Transaction sequencer. Requests are sampled only in IDLE.
    // The memory address and data stay valid through ISSUE and WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            ack_vec    <= 2'b00;
            rdata      <= 32'd0;
            mem_addr   <= 15'd0;
            mem_wdata  <= 32'd0;
            mem_w      <= 1'b0;
            mem_start  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        lat_we    <= we_vec[winner];
                        grant     <= winner ? 2'b10 : 2'b01;
                        mem_addr  <= addr_vec[winner];
                        mem_wdata <= wdata_vec[winner];
                        mem_w     <= we_vec[winner];
                        mem_start <= ~we_vec[winner];
                    end
                end
                ISSUE: begin
                    // The strobes last one cycle. Any completion seen here is ignored.
                    state     <= WAIT;
                    mem_w     <= 1'b0;
                    mem_start <= 1'b0;
                end
                WAIT: begin
                    if (done || timed_out) begin
                        state     <= ACK;
                        ack_vec   <= grant;
                        mem_addr  <= 15'd0;
                        mem_wdata <= 32'd0;
                        if (done && !lat_we) begin
                            rdata <= mem_rdata;
                        end
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    ack_vec    <= 2'b00;
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    last_grant <= grant[1];
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. A scoreboard queue receives the expected ack for each
// request when the request is driven. The monitor pops an entry on every ack.
// A small memory responder answers mem_start and mem_w after a programmable delay.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int TCYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, busy, mem_w, mem_start;
    logic [31:0] rdata, mem_wdata;
    logic [1:0]  grant;
    logic [14:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_readrdy = 1'b0, mem_saverdy = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w), .mem_start(mem_start),
        .mem_rdata(mem_rdata), .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Contents of the memory as the bench sees them.
    function automatic logic [31:0] mem_fn(input logic [14:0] a);
        if (a == 15'h0801) return 32'hDEADBEEF;
        return {8'hA5, 9'd0, a};
    endfunction

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rdata = '0;

    // Memory responder. It is configured by the main thread and never writes req*.
    int          rdy_delay = 1;
    bit          rdy_enable = 1'b1;
    bit          opp_first = 1'b0;
    int          pend = 0;
    bit          pend_we = 1'b0;
    bit          pend_opp = 1'b0;
    logic [14:0] pend_addr = '0;
    int          start_cyc = 0;
    int          w_cyc = 0;
    logic [14:0] strobe_addr = '0;
    logic [31:0] strobe_wdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            mem_readrdy = 1'b0;
            mem_saverdy = 1'b0;
            if (rst) pend = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    check_val("mem_addr_wait", 64'(mem_addr), 64'(pend_addr));
                    if (pend_opp) begin
                        // Raise the wrong strobe first. The right strobe follows two cycles later.
                        pend_opp = 1'b0;
                        if (pend_we) begin
                            mem_readrdy = 1'b1;
                            mem_rdata   = 32'hBAD0BAD0;
                        end else begin
                            mem_saverdy = 1'b1;
                        end
                        pend = 2;
                    end else if (pend_we) begin
                        mem_saverdy = 1'b1;
                    end else begin
                        mem_readrdy = 1'b1;
                        mem_rdata   = mem_fn(pend_addr);
                    end
                end
            end
            if (mem_start) start_cyc++;
            if (mem_w) w_cyc++;
            if ((mem_start || mem_w) && pend == 0) begin
                strobe_addr  = mem_addr;
                strobe_wdata = mem_wdata;
                if (rdy_enable) begin
                    pend_we   = mem_w;
                    pend_addr = mem_addr;
                    pend_opp  = opp_first;
                    pend      = rdy_delay;
                end
            end
        end
    end

    // Ack monitor. It also records the collapsed grant sequence when asked.
    logic [1:0] gseq[$];
    bit         grec = 1'b0;
    logic [1:0] glast = 2'b00;
    exp_t       mon_e;
    logic [1:0] mon_ack;

    initial begin
        forever begin
            @(negedge clk);
            if (grec && grant !== glast) begin
                gseq.push_back(grant);
                glast = grant;
            end
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_ack", 64'({ack1, ack0}), 64'd0);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_ack = (mon_e.port == 1) ? 2'b10 : 2'b01;
                    check_val("ack_port", 64'({ack1, ack0}), 64'(mon_ack));
                    check_val("ack_grant", 64'(grant), 64'(mon_ack));
                    check_val("ack_err", 64'(err), 64'(mon_e.err));
                    check_val("ack_rdata", 64'(rdata), 64'(mon_e.rdata));
                    check_val("ack_mem_addr_zero", 64'(mem_addr), 64'd0);
                    check_val("ack_busy", 64'(busy), 64'd1);
                    $display("txn: port=%0d err=%0d rdata=%08h t=%0t", mon_e.port, err, rdata, $time);
                end
            end
        end
    end

    task automatic push_exp(input int port, input bit we, input logic [14:0] a, input bit e);
        exp_t x;
        if (!we && !e) model_rdata = mem_fn(a);
        x.port  = port;
        x.err   = e;
        x.rdata = model_rdata;
        sb.push_back(x);
    endtask

    task automatic drive_req(input int port, input bit we, input logic [14:0] a, input logic [31:0] d);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end
    endtask

    // Wait until n acks have been seen, within a budget of clock cycles.
    // Both requests are dropped in the cycle of the last ack.
    task automatic wait_acks(input int n, input int budget, output int cyc);
        int seen;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (ack0 || ack1) seen++;
        end
        if (seen < n) check_val("ack_wait_expired", 64'(seen), 64'(n));
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic single_txn(input int port, input bit we, input logic [14:0] a, input logic [31:0] d,
                              input int dly, input bit opp, input int exp_lat, input string tag);
        int cyc;
        int s0;
        int w0;
        @(negedge clk);
        rdy_delay  = dly;
        opp_first  = opp;
        rdy_enable = 1'b1;
        s0 = start_cyc;
        w0 = w_cyc;
        push_exp(port, we, a, 1'b0);
        drive_req(port, we, a, d);
        wait_acks(1, 60, cyc);
        check_val({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_val({tag, "_start_cycles"}, 64'(start_cyc - s0), we ? 64'd0 : 64'd1);
        check_val({tag, "_w_cycles"}, 64'(w_cyc - w0), we ? 64'd1 : 64'd0);
        check_val({tag, "_strobe_addr"}, 64'(strobe_addr), 64'(a));
        if (we) check_val({tag, "_strobe_wdata"}, 64'(strobe_wdata), 64'(d));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_grant"}, 64'(grant), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_ack"}, 64'({ack1, ack0}), 64'd0);
        check_val({tag, "_err"}, 64'(err), 64'd0);
        check_val({tag, "_rdata"}, 64'(rdata), 64'd0);
        check_val({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check_val({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check_val({tag, "_mem_strobes"}, 64'({mem_w, mem_start}), 64'd0);
    endtask

    logic [1:0] gexp [5];
    int         cyc_main;

    initial begin
        gexp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

        // State immediately after reset
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Port 0 read: memory answers two cycles after mem_start
        single_txn(0, 1'b0, 15'h0801, 32'h0, 2, 1'b0, 4, "p0_read");
        // Port 1 write: rdata must keep DEADBEEF
        single_txn(1, 1'b1, 15'h1000, 32'h12345678, 2, 1'b0, 4, "p1_write");
        // Fastest path: ready in the first WAIT cycle
        single_txn(1, 1'b0, 15'h0123, 32'h0, 1, 1'b0, 3, "p1_read_min");
        // A strobe of the wrong type comes first and must be ignored
        single_txn(0, 1'b1, 15'h0444, 32'hCAFEF00D, 1, 1'b1, 5, "p0_write_opp");
        single_txn(1, 1'b0, 15'h0555, 32'h0, 1, 1'b1, 5, "p1_read_opp");

        // Both ports request together after reset and keep requesting
        do_reset();
        @(negedge clk);
        rdy_delay = 1; opp_first = 1'b0; rdy_enable = 1'b1;
        gseq.delete();
        glast = 2'b00;
        grec  = 1'b1;
        push_exp(0, 1'b0, 15'h0011, 1'b0);
        push_exp(1, 1'b0, 15'h0022, 1'b0);
        push_exp(0, 1'b0, 15'h0011, 1'b0);
        drive_req(0, 1'b0, 15'h0011, 32'h0);
        drive_req(1, 1'b0, 15'h0022, 32'h0);
        wait_acks(3, 100, cyc_main);
        grec = 1'b0;
        check_val("tie_gseq_len", 64'(gseq.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("tie_gseq_%0d", i), (i < gseq.size()) ? 64'(gseq[i]) : 64'h3, 64'(gexp[i]));
        end

        // Reset in the middle of a port 0 read that is waiting on memory
        @(negedge clk);
        rdy_enable = 1'b0;
        drive_req(0, 1'b0, 15'h0333, 32'h0);
        @(negedge clk);
        check_val("abort_issue_start", 64'(mem_start), 64'd1);
        @(negedge clk);
        check_val("abort_wait_addr", 64'(mem_addr), 64'h0333);
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort_async");
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;

        // The next tie must go to port 0 first
        @(negedge clk);
        rdy_delay = 1; rdy_enable = 1'b1;
        push_exp(0, 1'b0, 15'h0066, 1'b0);
        push_exp(1, 1'b0, 15'h0077, 1'b0);
        drive_req(0, 1'b0, 15'h0066, 32'h0);
        drive_req(1, 1'b0, 15'h0077, 32'h0);
        wait_acks(2, 60, cyc_main);

`ifdef MEM_ARB_TIMEOUT_EN
        // Read that is never answered: must time out with err after TCYC WAIT cycles
        @(negedge clk);
        rdy_enable = 1'b0;
        push_exp(0, 1'b0, 15'h0099, 1'b1);
        drive_req(0, 1'b0, 15'h0099, 32'h0);
        wait_acks(1, 60, cyc_main);
        check_val("timeout_latency", 64'(cyc_main), 64'(2 + TCYC));
`else
        // Read that is never answered: must keep waiting with no ack
        @(negedge clk);
        rdy_enable = 1'b0;
        drive_req(0, 1'b0, 15'h0099, 32'h0);
        repeat (30) @(negedge clk);
        check_val("no_timeout_busy", 64'(busy), 64'd1);
        check_val("no_timeout_err", 64'(err), 64'd0);
        check_val("no_timeout_addr_held", 64'(mem_addr), 64'h0099);
        req0 = 1'b0;
        do_reset();
`endif

        repeat (3) @(negedge clk);
        check_val("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
